// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared CPU bus source map and sizing helper
package bus_pkg;

   // Select width for an N-way choice; never narrower than one bit.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

   // Default 24-source CPU bus map.
   localparam int SRC_R0     = 0;
   localparam int SRC_R15    = 15;
   localparam int SRC_HI     = 16;
   localparam int SRC_LO     = 17;
   localparam int SRC_ZHI    = 18;
   localparam int SRC_ZLO    = 19;
   localparam int SRC_PC     = 20;
   localparam int SRC_MDR    = 21;
   localparam int SRC_INPORT = 22;
   localparam int SRC_CSIGN  = 23;
   localparam int CPU_N_SRC  = 24;

endpackage

// File: rtl/prio_onehot_enc.sv
// rtl/prio_onehot_enc.sv - priority encoder with any/multi detection, index 0 wins
module prio_onehot_enc
   import bus_pkg::*;
#(
   parameter int N     = 24,
   parameter int SEL_W = clog2_min1(N)
) (
   input  logic [N-1:0]     en,
   output logic [SEL_W-1:0] win,
   output logic             any,
   output logic             multi
);

   // Scan downward so the lowest set index is the last assignment and wins.
   always_comb begin
      win = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (en[i]) win = SEL_W'(i);
      end
      any   = |en;
      // Clearing the lowest set bit leaves something only if two or more were set.
      multi = |(en & (en - {{(N-1){1'b0}}, 1'b1}));
   end

endmodule

// File: rtl/bus_source_arbiter.sv
// rtl/bus_source_arbiter.sv - N-source bus select with hold and conflict tracking
module bus_source_arbiter
   import bus_pkg::*;
#(
   parameter int N_SRC   = 24,
   parameter int WIDTH   = 32,
   parameter bit REG_OUT = 1'b1,
   parameter bit HOLD    = 1'b1,
   parameter int CNT_W   = 8,
   localparam int SEL_W  = clog2_min1(N_SRC)
) (
   input  logic                   clk,
   input  logic                   clr_n,
   input  logic [N_SRC*WIDTH-1:0] src_data,
   input  logic [N_SRC-1:0]       src_en,
   input  logic                   err_clr,
   output logic [WIDTH-1:0]       bus_out,
   output logic [SEL_W-1:0]       bus_sel,
   output logic                   bus_valid,
   output logic                   conflict,
   output logic                   conflict_sticky,
   output logic [CNT_W-1:0]       conflict_cnt
);

   logic [SEL_W-1:0] win;
   logic             any;
   logic             multi;
   logic [WIDTH-1:0] win_data;
   logic [WIDTH-1:0] hold_q;
   logic [SEL_W-1:0] sel_hold_q;
   logic [WIDTH-1:0] nxt_bus;
   logic [SEL_W-1:0] nxt_sel;

   prio_onehot_enc #(.N(N_SRC), .SEL_W(SEL_W)) u_enc (
      .en    (src_en),
      .win   (win),
      .any   (any),
      .multi (multi)
   );

   // Pick the winning source's word; only one slice is ever forwarded.
   always_comb begin
      win_data = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (win == SEL_W'(i)) win_data = src_data[i*WIDTH +: WIDTH];
      end
   end

   // Next bus value and index, falling back to the held pair (or zero) when idle.
   always_comb begin
      nxt_bus = '0;
      nxt_sel = '0;
      if (any) begin
         nxt_bus = win_data;
         nxt_sel = win;
      end else if (HOLD) begin
         nxt_bus = hold_q;
         nxt_sel = sel_hold_q;
      end
   end

   // Remember the last driven value and index for bus-hold.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         hold_q     <= '0;
         sel_hold_q <= '0;
      end else if (any) begin
         hold_q     <= win_data;
         sel_hold_q <= win;
      end
   end

   generate
      if (REG_OUT) begin : g_reg
         // Registered output stage: cycle-N selection visible after edge N.
         always_ff @(posedge clk or negedge clr_n) begin
            if (!clr_n) begin
               bus_out   <= '0;
               bus_sel   <= '0;
               bus_valid <= 1'b0;
               conflict  <= 1'b0;
            end else begin
               bus_out   <= nxt_bus;
               bus_sel   <= nxt_sel;
               bus_valid <= any;
               conflict  <= multi;
            end
         end
      end else begin : g_comb
         // Combinational outputs are forced to zero while reset is held.
         assign bus_out   = clr_n ? nxt_bus : '0;
         assign bus_sel   = clr_n ? nxt_sel : '0;
         assign bus_valid = clr_n & any;
         assign conflict  = clr_n & multi;
      end
   endgenerate

   // Sticky conflict flag and saturating counter; a new conflict beats err_clr.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         conflict_sticky <= 1'b0;
         conflict_cnt    <= '0;
      end else if (multi) begin
         conflict_sticky <= 1'b1;
         if (err_clr)
            conflict_cnt <= CNT_W'(1);
         else if (conflict_cnt != {CNT_W{1'b1}})
            conflict_cnt <= conflict_cnt + CNT_W'(1);
      end else if (err_clr) begin
         conflict_sticky <= 1'b0;
         conflict_cnt    <= '0;
      end
   end

endmodule

// File: tb/tb_bus_source_arbiter.sv
// tb/tb_bus_source_arbiter.sv - directed self-checking bench for bus_source_arbiter
module tb_bus_source_arbiter;
   import bus_pkg::*;

   localparam int N  = 24;
   localparam int W  = 32;
   localparam int SW = 5;
   localparam int CW = 8;

   logic           clk;
   logic           clr_n;
   logic [N*W-1:0] src_data;
   logic [N-1:0]   src_en;
   logic           err_clr;

   logic [W-1:0]  a_bus, b_bus, c_bus;
   logic [SW-1:0] a_sel, b_sel, c_sel;
   logic          a_val, b_val, c_val;
   logic          a_con, b_con, c_con;
   logic          a_stk, b_stk, c_stk;
   logic [CW-1:0] a_cnt, b_cnt, c_cnt;

   int checks = 0;
   int errors = 0;

   bus_source_arbiter #(.N_SRC(N), .WIDTH(W), .REG_OUT(1'b1), .HOLD(1'b1), .CNT_W(CW)) dut (
      .clk(clk), .clr_n(clr_n), .src_data(src_data), .src_en(src_en), .err_clr(err_clr),
      .bus_out(a_bus), .bus_sel(a_sel), .bus_valid(a_val), .conflict(a_con),
      .conflict_sticky(a_stk), .conflict_cnt(a_cnt));

   bus_source_arbiter #(.N_SRC(N), .WIDTH(W), .REG_OUT(1'b1), .HOLD(1'b0), .CNT_W(CW)) dut_h0 (
      .clk(clk), .clr_n(clr_n), .src_data(src_data), .src_en(src_en), .err_clr(err_clr),
      .bus_out(b_bus), .bus_sel(b_sel), .bus_valid(b_val), .conflict(b_con),
      .conflict_sticky(b_stk), .conflict_cnt(b_cnt));

   bus_source_arbiter #(.N_SRC(N), .WIDTH(W), .REG_OUT(1'b0), .HOLD(1'b1), .CNT_W(CW)) dut_c (
      .clk(clk), .clr_n(clr_n), .src_data(src_data), .src_en(src_en), .err_clr(err_clr),
      .bus_out(c_bus), .bus_sel(c_sel), .bus_valid(c_val), .conflict(c_con),
      .conflict_sticky(c_stk), .conflict_cnt(c_cnt));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clr_n   = 1'b0;
      src_en  = '0;
      err_clr = 1'b0;
      for (int i = 0; i < N; i++) src_data[i*W +: W] = 32'h1000_0000 + 32'(i);
      #12;

      chk("rst_bus",    64'(a_bus), 64'h0);
      chk("rst_sel",    64'(a_sel), 64'h0);
      chk("rst_valid",  64'(a_val), 64'h0);
      chk("rst_conf",   64'(a_con), 64'h0);
      chk("rst_sticky", 64'(a_stk), 64'h0);
      chk("rst_cnt",    64'(a_cnt), 64'h0);

      clr_n  = 1'b1;
      src_en = 24'(1) << 5;
      tick();
      chk("sel5_bus",   64'(a_bus), 64'h1000_0005);
      chk("sel5_sel",   64'(a_sel), 64'd5);
      chk("sel5_valid", 64'(a_val), 64'd1);
      chk("sel5_conf",  64'(a_con), 64'd0);
      chk("h0_sel5_bus", 64'(b_bus), 64'h1000_0005);

      src_en = '0;
      tick();
      chk("hold_bus",    64'(a_bus), 64'h1000_0005);
      chk("hold_sel",    64'(a_sel), 64'd5);
      chk("hold_valid",  64'(a_val), 64'd0);
      chk("h0_idle_bus", 64'(b_bus), 64'h0);
      chk("h0_idle_sel", 64'(b_sel), 64'h0);
      chk("h0_idle_val", 64'(b_val), 64'h0);

      src_en = (24'(1) << 20) | (24'(1) << 3);
      tick();
      chk("multi_bus",    64'(a_bus), 64'h1000_0003);
      chk("multi_sel",    64'(a_sel), 64'd3);
      chk("multi_valid",  64'(a_val), 64'd1);
      chk("multi_conf",   64'(a_con), 64'd1);
      chk("multi_sticky", 64'(a_stk), 64'd1);
      chk("multi_cnt",    64'(a_cnt), 64'd1);

      src_en  = '0;
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("clr_sticky", 64'(a_stk), 64'd0);
      chk("clr_cnt",    64'(a_cnt), 64'd0);
      chk("clr_conf",   64'(a_con), 64'd0);

      src_en = (24'(1) << 20) | (24'(1) << 3);
      for (int i = 0; i < 300; i++) tick();
      chk("sat_cnt",    64'(a_cnt), 64'd255);
      chk("sat_sticky", 64'(a_stk), 64'd1);
      tick();
      chk("sat_cnt_stay", 64'(a_cnt), 64'd255);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("clr_vs_multi_cnt",    64'(a_cnt), 64'd1);
      chk("clr_vs_multi_sticky", 64'(a_stk), 64'd1);

      src_en = 24'(1) << 23;
      tick();
      chk("pre_rst_bus",    64'(a_bus), 64'h1000_0017);
      chk("pre_rst_sticky", 64'(a_stk), 64'd1);
      #2;
      clr_n = 1'b0;
      #1;
      chk("arst_bus",    64'(a_bus), 64'h0);
      chk("arst_sel",    64'(a_sel), 64'h0);
      chk("arst_valid",  64'(a_val), 64'h0);
      chk("arst_sticky", 64'(a_stk), 64'h0);
      chk("arst_cnt",    64'(a_cnt), 64'h0);
      chk("arst_c_bus",  64'(c_bus), 64'h0);
      chk("arst_c_val",  64'(c_val), 64'h0);
      #1;
      clr_n  = 1'b1;
      src_en = 24'(1) << 7;
      tick();
      chk("post_rst_bus", 64'(a_bus), 64'h1000_0007);
      chk("post_rst_sel", 64'(a_sel), 64'd7);

      src_en = 24'(1) << 23;
      #1;
      chk("comb_bus", 64'(c_bus), 64'h1000_0017);
      chk("comb_sel", 64'(c_sel), 64'd23);
      chk("comb_val", 64'(c_val), 64'd1);
      tick();

      for (int i = 0; i < N; i++) begin
         src_en = 24'(1) << i;
         #1;
         chk("walk_comb_bus", 64'(c_bus), 64'h1000_0000 + 64'(i));
         chk("walk_comb_sel", 64'(c_sel), 64'(i));
         tick();
         chk("walk_reg_bus", 64'(a_bus), 64'h1000_0000 + 64'(i));
      end

      src_en = '0;
      #1;
      chk("comb_hold_bus", 64'(c_bus), 64'h1000_0017);
      chk("comb_hold_sel", 64'(c_sel), 64'd23);
      chk("comb_hold_val", 64'(c_val), 64'd0);

      src_en = '1;
      #1;
      chk("comb_all_bus",  64'(c_bus), 64'h1000_0000);
      chk("comb_all_sel",  64'(c_sel), 64'd0);
      chk("comb_all_conf", 64'(c_con), 64'd1);
      tick();
      chk("all_c_cnt", 64'(c_cnt), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_source_arbiter.md
Name: bus_source_arbiter

Overview:
- Parametrised successor to the datapath's fixed 24-source bus multiplexer.
- Accepts N one-hot "Xout" drive enables and produces the encoded source index, the bus value, and a valid strobe, with an optional registered output stage.
- Adds bus-hold when no source drives, and multi-driver conflict detection with a sticky flag and a saturating counter.
- Sits between the register file/special registers and the CPU bus, replacing encoder plus mux.

Parameters:
- N_SRC, 24, number of bus sources (2..64); index 0 is highest priority.
- WIDTH, 32, bus data width in bits.
- REG_OUT, 1, 1 = bus outputs registered (latency 1); 0 = combinational (latency 0).
- HOLD, 1, 1 = bus retains the last driven value when idle; 0 = bus reads zero when idle.
- CNT_W, 8, width of the conflict counter.

Ports:
- clk, in, 1, rising-edge clock.
- clr_n, in, 1, asynchronous active-low reset.
- src_data, in, N_SRC*WIDTH, flattened source values; source i occupies bits [i*WIDTH +: WIDTH].
- src_en, in, N_SRC, per-source drive enables, expected one-hot or zero.
- err_clr, in, 1, synchronous clear of conflict_sticky and conflict_cnt.
- bus_out, out, WIDTH, selected bus value.
- bus_sel, out, SEL_W = max(1, clog2(N_SRC)), encoded index of the winning source.
- bus_valid, out, 1, high when at least one enable was asserted.
- conflict, out, 1, high when two or more enables were asserted.
- conflict_sticky, out, 1, latched conflict indication.
- conflict_cnt, out, CNT_W, saturating count of conflict cycles.

Behaviour:
- Reset (clr_n low, asynchronous):
  - bus_out = 0, bus_sel = 0, bus_valid = 0, conflict = 0, conflict_sticky = 0, conflict_cnt = 0.
  - The hold register is cleared to 0.
  - Outputs stay at these values for the whole time clr_n is low; leaving reset mid-operation needs no flush.
- Arbitration (combinational core):
  - win = lowest index i with src_en[i] = 1.
  - any = OR of src_en.
  - multi = two or more enables set (popcount of 2 or more).
- Next bus value:
  - any = 1: src_data[win].
  - any = 0, HOLD = 1: hold register.
  - any = 0, HOLD = 0: 0.
- Next bus_sel:
  - any = 1: win.
  - any = 0: previous bus_sel when HOLD = 1, 0 when HOLD = 0.
- Hold register: loads src_data[win] on every clock edge where any = 1; unchanged otherwise.
- Output timing:
  - REG_OUT = 1: bus_out, bus_sel, bus_valid and conflict register the next-values; values for cycle-N enables appear after edge N.
  - REG_OUT = 0: the same signals are driven combinationally from the current inputs, including the hold register.
- Sticky flag and counter (always registered, independent of REG_OUT):
  - multi = 1: conflict_sticky <= 1; conflict_cnt <= cnt + 1, saturating at 2^CNT_W - 1 with no wrap.
  - err_clr = 1 and multi = 0: conflict_sticky <= 0, conflict_cnt <= 0.
  - err_clr = 1 and multi = 1 in the same cycle: the new conflict wins; sticky = 1, cnt = 1.
- Conflicting enables still produce a defined output: the lowest index is driven, bus_valid = 1, conflict = 1.
- Source data is never ORed across multiple enables.
- Sources beyond N_SRC do not exist; no out-of-range decode is possible.
- Enables are sampled every cycle with no handshake; back-to-back selections of different sources produce back-to-back values.

Decomposition:
- Shared package bus_pkg:
  - function clog2_min1.
  - Localparam defaults for the 24-source CPU map: R0-R15 = 0-15, HI = 16, LO = 17, ZHI = 18, ZLO = 19, PC = 20, MDR = 21, INPORT = 22, CSIGN = 23.
  - Shared by the control unit.
- One natural sub-module, prio_onehot_enc (parametrised N):
  - Inputs: enable vector.
  - Outputs: win index, any, multi.
  - Purely combinational, reusable by the interrupt logic.
- Top level holds the data select, hold register, output stage and counter.

Test Plan (N_SRC = 24, WIDTH = 32, REG_OUT = 1, HOLD = 1, CNT_W = 8):
- Reset, then drive src_data[i] = 0x1000_0000 + i and src_en = 1 << 5 for one cycle → after the edge: bus_out = 0x1000_0005, bus_sel = 5, bus_valid = 1, conflict = 0.
- Next cycle src_en = 0 → bus_out stays 0x1000_0005, bus_sel = 5, bus_valid = 0. Repeat with HOLD = 0 → bus_out = 0, bus_sel = 0.
- src_en = (1 << 20) | (1 << 3) → bus_out = 0x1000_0003, bus_sel = 3, conflict = 1, conflict_sticky = 1, conflict_cnt = 1. A single err_clr pulse afterwards → sticky = 0, cnt = 0.
- Hold multi-enable for 300 cycles → conflict_cnt saturates at 255 and stays there. Then assert err_clr and multi in the same cycle → cnt = 1, sticky = 1.
- Pulse clr_n low asynchronously between edges while bus_out = 0x1000_0017 → all outputs read 0 immediately. The first select after release reaches bus_out on the first edge.
- REG_OUT = 0, src_en = 1 << 23 → bus_out = 0x1000_0017 in the same cycle with no edge. Walk src_en from 1 << 0 to 1 << 23 on consecutive cycles → each index appears on consecutive cycles.
